// File: rtl/board_io_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : board_io_ctrl_if
//  Brief    : Avalon-MM slave bus bundle for board_io_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
interface board_io_ctrl_if;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_readdatavalid
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_readdatavalid
    );
endinterface
`default_nettype wire

// File: rtl/board_io_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : board_io_ctrl
//  Brief    : LED driver with blink, debounced switches with edge IRQ, MM regs.
//  Revision : 1.0 - initial release
// ============================================================================
module board_io_ctrl #(
    parameter int          N_LED           = 8,
    parameter int          N_SW            = 4,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter logic [31:0] BLINK_DEFAULT   = 32'd24999999
) (
    input  wire logic             clk_clk,
    input  wire logic             reset_reset,
    board_io_ctrl_if.slave        avs,
    input  wire logic [N_SW-1:0]  sw,
    output logic      [N_LED-1:0] led,
    output logic                  irq
);

    localparam int               c_cnt_w      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       c_addr_led   = 3'd0;
    localparam logic [2:0]       c_addr_blink = 3'd1;
    localparam logic [2:0]       c_addr_div   = 3'd2;
    localparam logic [2:0]       c_addr_state = 3'd3;
    localparam logic [2:0]       c_addr_edge  = 3'd4;
    localparam logic [2:0]       c_addr_mask  = 3'd5;

    logic [N_LED-1:0] r_led_data;
    logic [N_LED-1:0] r_led_blink;
    logic [31:0]      r_blink_div;
    logic [31:0]      r_blink_cnt;
    logic             r_phase;
    logic [N_SW-1:0]  r_sw_edge;
    logic [N_SW-1:0]  r_irq_mask;
    logic [N_SW-1:0]  r_sync1;
    logic [N_SW-1:0]  r_sync2;
    logic [31:0]      r_readdata;
    logic             r_readdatavalid;

    logic [N_SW-1:0]  w_sw_state;
    logic [N_SW-1:0]  w_edge_set;
    logic [N_SW-1:0]  w_edge_clr;
    logic [31:0]      w_rd_data;
    logic             w_wr_led;
    logic             w_wr_blink;
    logic             w_wr_div;
    logic             w_wr_edge;
    logic             w_wr_mask;
    logic             w_unused;

    assign w_wr_led   = avs.avs_write && (avs.avs_address == c_addr_led);
    assign w_wr_blink = avs.avs_write && (avs.avs_address == c_addr_blink);
    assign w_wr_div   = avs.avs_write && (avs.avs_address == c_addr_div);
    assign w_wr_edge  = avs.avs_write && (avs.avs_address == c_addr_edge);
    assign w_wr_mask  = avs.avs_write && (avs.avs_address == c_addr_mask);
    assign w_edge_clr = w_wr_edge ? avs.avs_writedata[N_SW-1:0] : '0;
    assign w_unused   = ^avs.avs_writedata;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
        end
    end

    // Counter runs only while the synchronized input disagrees with the
    // accepted level; any agreement restarts the qualification window.
    for (genvar gi = 0; gi < N_SW; gi++) begin : g_debounce
        logic [c_cnt_w-1:0] r_cnt;
        logic               r_d;

        always_ff @(posedge clk_clk) begin
            if (reset_reset) begin
                r_cnt <= '0;
                r_d   <= 1'b0;
            end else if (r_sync2[gi] != r_d) begin
                if (r_cnt == c_cnt_max) begin
                    r_cnt <= '0;
                    r_d   <= r_sync2[gi];
                end else begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end

        assign w_sw_state[gi] = r_d;
        assign w_edge_set[gi] = (r_sync2[gi] != r_d) && (r_cnt == c_cnt_max);
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_led_data  <= '0;
            r_led_blink <= '0;
            r_blink_div <= BLINK_DEFAULT;
            r_irq_mask  <= '0;
            r_sw_edge   <= '0;
        end else begin
            if (w_wr_led)   r_led_data  <= avs.avs_writedata[N_LED-1:0];
            if (w_wr_blink) r_led_blink <= avs.avs_writedata[N_LED-1:0];
            if (w_wr_div)   r_blink_div <= avs.avs_writedata;
            if (w_wr_mask)  r_irq_mask  <= avs.avs_writedata[N_SW-1:0];
            // A same-cycle debounce event must survive a clear
            r_sw_edge <= (r_sw_edge & ~w_edge_clr) | w_edge_set;
        end
    end

    // Restarting on a divider write keeps a smaller divider from being overshot
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (w_wr_div) begin
            r_blink_cnt <= '0;
        end else if (r_blink_cnt == r_blink_div) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + 32'd1;
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (avs.avs_address)
            c_addr_led:   w_rd_data[N_LED-1:0] = r_led_data;
            c_addr_blink: w_rd_data[N_LED-1:0] = r_led_blink;
            c_addr_div:   w_rd_data            = r_blink_div;
            c_addr_state: w_rd_data[N_SW-1:0]  = w_sw_state;
            c_addr_edge:  w_rd_data[N_SW-1:0]  = r_sw_edge;
            c_addr_mask:  w_rd_data[N_SW-1:0]  = r_irq_mask;
            default:      w_rd_data            = '0;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_readdata      <= '0;
            r_readdatavalid <= 1'b0;
            led             <= '0;
            irq             <= 1'b0;
        end else begin
            r_readdatavalid <= avs.avs_read;
            if (avs.avs_read) r_readdata <= w_rd_data;
            led <= r_led_data & (~r_led_blink | {N_LED{r_phase}});
            irq <= |(r_sw_edge & r_irq_mask);
        end
    end

    assign avs.avs_readdata      = r_readdata;
    assign avs.avs_readdatavalid = r_readdatavalid;

endmodule
`default_nettype wire

// File: doc/board_io_ctrl.md
BOARD_IO_CTRL -- requirements
Module: board_io_ctrl

Interface
REQ-001 SHALL have parameter N_LED, default 8, number of LED outputs (range 1..16).
REQ-002 SHALL have parameter N_SW, default 4, number of switch inputs (range 1..16).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 50000, stable cycles needed to accept a switch change (minimum 2).
REQ-004 SHALL have parameter BLINK_DEFAULT, default 24999999, reset value of BLINK_DIV.
REQ-005 SHALL have port clk_clk, input, 1, the single clock for all logic.
REQ-006 SHALL have port reset_reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port avs_address, input, 3, register word address.
REQ-008 SHALL have port avs_read, input, 1, read strobe.
REQ-009 SHALL have port avs_write, input, 1, write strobe.
REQ-010 SHALL have port avs_writedata, input, 32, write data.
REQ-011 SHALL have port avs_readdata, output, 32, read data, registered.
REQ-012 SHALL have port avs_readdatavalid, output, 1, read data qualifier.
REQ-013 SHALL have port sw, input, N_SW, asynchronous board switches.
REQ-014 SHALL have port led, output, N_LED, board LEDs, registered.
REQ-015 SHALL have port irq, output, 1, level interrupt, registered.

Function
REQ-016 SHALL map the registers as follows: 0 LED_DATA RW; 1 LED_BLINK RW; 2 BLINK_DIV RW (32 bit); 3 SW_STATE RO; 4 SW_EDGE W1C; 5 IRQ_MASK RW; 6-7 read 0, writes ignored.
REQ-017 SHALL make register fields N_LED or N_SW bits wide, LSB-aligned; unused readdata bits read 0 and unused writedata bits are ignored.
REQ-018 SHALL have fixed read latency: avs_readdata and avs_readdatavalid valid exactly 1 cycle after avs_read; avs_readdatavalid is high for 1 cycle per read.
REQ-019 SHALL, when read and write target the same address in the same cycle, commit the write and return the pre-write value.
REQ-020 SHALL accept writes with no wait states; a back-to-back read or write is accepted on every cycle.
REQ-021 SHALL pass each sw bit through a 2-flop synchronizer; the synchronized bit is s.
REQ-022 SHALL give each switch a debounced bit d and a counter: counter reset to 0 when s==d; otherwise incremented.
REQ-023 SHALL, when the counter reaches DEBOUNCE_CYCLES-1, load d<=s, clear the counter, and set SW_EDGE[i] in that same cycle.
REQ-024 SHALL ignore glitches shorter than DEBOUNCE_CYCLES cycles (counter clears, d unchanged).
REQ-025 SHALL update SW_STATE 2+DEBOUNCE_CYCLES cycles after a clean sw transition.
REQ-026 SHALL clear SW_EDGE bits by writing 1; if a set and a clear hit the same bit in the same cycle, the set wins.
REQ-027 SHALL register irq <= |(SW_EDGE & IRQ_MASK), which is 1 cycle behind the register state.
REQ-028 SHALL run a 32-bit blink counter: when the counter equals BLINK_DIV, counter<=0 and the blink phase toggles; otherwise counter+1.
REQ-029 SHALL clear the blink counter on any write to BLINK_DIV, so a lower BLINK_DIV never causes a wrap through 2^32.
REQ-030 SHALL toggle the phase every cycle when BLINK_DIV is 0.
REQ-031 SHALL register led[i] <= LED_DATA[i] & (~LED_BLINK[i] | phase), 1 cycle after the inputs change.

Reset
REQ-032 SHALL, on reset, set LED_DATA, LED_BLINK, IRQ_MASK, SW_EDGE, SW_STATE, synchronizers, counters, phase, led, irq, avs_readdata and avs_readdatavalid to 0, and BLINK_DIV to BLINK_DEFAULT.
REQ-033 SHALL let reset override any in-flight read (no readdatavalid the next cycle) and any debounce in progress.
REQ-034 SHALL, after reset with a switch held high, debounce it to 1 normally and set its SW_EDGE bit.

Verification
REQ-035 Bench SHALL cover: write LED_DATA=0xA5, LED_BLINK=0 -> led=0xA5 one cycle later; read addr 0 -> readdata 0xA5, valid exactly 1 cycle after read.
REQ-036 Bench SHALL cover (DEBOUNCE_CYCLES=8): sw[0] rises cleanly -> SW_STATE[0]=1 and SW_EDGE[0]=1 after 10 cycles; a 5-cycle pulse on sw[1] -> no change.
REQ-037 Bench SHALL cover: IRQ_MASK=0x1 plus an edge on sw[0] -> irq=1 one cycle after SW_EDGE; write 0x1 to SW_EDGE -> irq=0 two cycles later; a set and a clear in the same cycle -> bit stays 1.
REQ-038 Bench SHALL cover: BLINK_DIV=3, LED_DATA=0xFF, LED_BLINK=0x0F -> led[3:0] toggles every 4 cycles and led[7:4] stays 1; write BLINK_DIV=0 mid-count -> counter cleared, toggling every cycle.
REQ-039 Bench SHALL cover: read/write to addr 5 in the same cycle -> old value returned, new value read next; reads of addr 6 and 7 -> 0.
REQ-040 Bench SHALL cover: reset asserted mid-debounce and the cycle after a read -> all outputs 0, no readdatavalid, BLINK_DIV reads 24999999.
